mux_bin_rr_stream: RTL

Parameterised N-input, one-output stream multiplexer with a valid/ready handshake on every channel, round-robin arbitration among requesting inputs, and a registered output stage. It is the sequential successor to the plain binary word multiplexer. The selector is no longer an input: the block chooses the source itself, fairly, and reports the chosen index alongside the word. It sits wherever several producers share one consumer (bus funnels, result write-back merges) and runs at full throughput of one word per cycle.

---
 rtl/mux_bin_rr_stream_pkg.sv | 8 +
 rtl/mux_bin_rr_stream_if.sv | 29 ++
 rtl/mux_bin_rr_stream_arbiter.sv | 36 +++
 rtl/mux_bin_rr_stream.sv | 65 ++++++
 4 files changed

// File: rtl/mux_bin_rr_stream_pkg.sv
// rtl/mux_bin_rr_stream_pkg.sv - default geometry shared by the stream mux and its bench
package mux_bin_rr_stream_pkg;

    localparam int DEFAULT_WORD_WIDTH  = 8;
    localparam int DEFAULT_INPUT_COUNT = 4;
    localparam int DEFAULT_ADDR_WIDTH  = 2;

endpackage

// File: rtl/mux_bin_rr_stream_if.sv
// rtl/mux_bin_rr_stream_if.sv - N-to-1 stream bundle: producer words/valids, consumer word/handshake
interface mux_bin_rr_stream_if
    import mux_bin_rr_stream_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int INPUT_COUNT = DEFAULT_INPUT_COUNT,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
);

    logic [WORD_WIDTH*INPUT_COUNT-1:0] words_in;
    logic [INPUT_COUNT-1:0]            valid_in;
    logic [INPUT_COUNT-1:0]            ready_in;
    logic [WORD_WIDTH-1:0]             word_out;
    logic [ADDR_WIDTH-1:0]             source_out;
    logic                              valid_out;
    logic                              ready_out;

    // master: producers plus consumer, i.e. everything around the mux
    modport master (
        output words_in, valid_in, ready_out,
        input  ready_in, word_out, source_out, valid_out
    );

    modport slave (
        input  words_in, valid_in, ready_out,
        output ready_in, word_out, source_out, valid_out
    );

endinterface

// File: rtl/mux_bin_rr_stream_arbiter.sv
// rtl/mux_bin_rr_stream_arbiter.sv - combinational round-robin grant: rotate, priority encode, un-rotate
module arbiter_rr_grant
    import mux_bin_rr_stream_pkg::*;
#(
    parameter int INPUT_COUNT = DEFAULT_INPUT_COUNT,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
    input  logic [INPUT_COUNT-1:0] valid_in,
    input  logic [ADDR_WIDTH-1:0]  pointer,
    output logic [ADDR_WIDTH-1:0]  grant,
    output logic                   grant_valid
);

    localparam logic [ADDR_WIDTH:0] COUNT = (ADDR_WIDTH+1)'(INPUT_COUNT);

    logic [2*INPUT_COUNT-1:0] doubled;
    logic [INPUT_COUNT-1:0]   rotated;
    logic [ADDR_WIDTH-1:0]    index;
    logic [ADDR_WIDTH:0]      sum;

    assign doubled     = {valid_in, valid_in};
    assign rotated     = doubled[pointer +: INPUT_COUNT];
    assign grant_valid = |valid_in;

    // Ternary chain keeps X on any valid bit visible in the encoded index.
    always_comb begin
        index = '0;
        for (int i = INPUT_COUNT - 1; i >= 0; i--) begin
            index = rotated[i] ? ADDR_WIDTH'(i) : index;
        end
    end

    assign sum   = {1'b0, pointer} + {1'b0, index};
    assign grant = ADDR_WIDTH'((sum >= COUNT) ? sum - COUNT : sum);

endmodule

// File: rtl/mux_bin_rr_stream.sv
// rtl/mux_bin_rr_stream.sv - N-input round-robin stream mux with registered word/source output
module mux_bin_rr_stream
    import mux_bin_rr_stream_pkg::*;
#(
    parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int INPUT_COUNT = DEFAULT_INPUT_COUNT,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [TOTAL_WIDTH-1:0] words_in,
    input  logic [INPUT_COUNT-1:0] valid_in,
    output logic [INPUT_COUNT-1:0] ready_in,
    output logic [WORD_WIDTH-1:0]  word_out,
    output logic [ADDR_WIDTH-1:0]  source_out,
    output logic                   valid_out,
    input  logic                   ready_out
);

    logic [ADDR_WIDTH-1:0] pointer;
    logic [ADDR_WIDTH-1:0] grant;
    logic                  grant_valid;
    logic                  space;
    logic                  load;
    logic [WORD_WIDTH-1:0] words [INPUT_COUNT];
    logic [WORD_WIDTH-1:0] word_sel;

    arbiter_rr_grant #(
        .INPUT_COUNT (INPUT_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_grant (
        .valid_in    (valid_in),
        .pointer     (pointer),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_unpack
        assign words[g] = words_in[g*WORD_WIDTH +: WORD_WIDTH];
    end

    assign word_sel = words[grant];
    assign space    = !valid_out || ready_out;
    // Clear masks the handshake so no producer sees a transfer that is then dropped.
    assign load     = grant_valid && space && !clear;
    assign ready_in = load ? (INPUT_COUNT'(1) << grant) : '0;

    always_ff @(posedge clock) begin
        if (clear) begin
            valid_out  <= 1'b0;
            word_out   <= '0;
            source_out <= '0;
            pointer    <= '0;
        end else if (load) begin
            valid_out  <= 1'b1;
            word_out   <= word_sel;
            source_out <= grant;
            pointer    <= (grant == ADDR_WIDTH'(INPUT_COUNT - 1)) ? '0 : grant + ADDR_WIDTH'(1);
        end else if (valid_out && ready_out) begin
            valid_out  <= 1'b0;
        end
    end

endmodule
